// File: rtl/fp27_pkg.sv
// Shared definitions for the 27-bit float format (1 sign, 8 exponent, 18 mantissa)
// and the sum sequencer FSM encoding.
package fp27_pkg;

  localparam int FP_W     = 27;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 18;
  localparam int EXP_BIAS = 127;

  localparam int SIGN_BIT = 26;
  localparam int EXP_MSB  = 25;
  localparam int EXP_LSB  = 18;
  localparam int MAN_MSB  = 17;
  localparam int MAN_LSB  = 0;

  localparam logic [FP_W-1:0] FP27_ZERO = 27'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fp_sum_sequencer.sv
// Serially accumulates each s_last-terminated packet of floats through an external
// fixed-latency adder and presents one sum (plus element count) per packet.
module fp_sum_sequencer
  import fp27_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk_pll,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [FP_W-1:0]  s_data,
  input  logic             s_last,
  output logic [FP_W-1:0]  add_a,
  output logic [FP_W-1:0]  add_b,
  input  logic [FP_W-1:0]  add_sum,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [FP_W-1:0]  m_data,
  output logic [CNT_W-1:0] m_count,
  output logic [1:0]       state_dbg
);

  localparam int LAT_W = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

  fsm_state_t       state, state_nxt;
  logic             started;
  logic [FP_W-1:0]  acc;
  logic [CNT_W-1:0] cnt;
  logic [LAT_W-1:0] lat;
  logic             last_q;
  logic             s_fire, m_fire, lat_done;

  // Handshakes: a beat moves on a rising edge where valid & ready are both high.
  // s_ready depends only on FSM state, m_valid only on FSM state (never on m_ready).
  always_comb begin
    s_ready   = started && (state == ST_IDLE || state == ST_ACC);
    m_valid   = (state == ST_DONE);
    s_fire    = s_valid && s_ready;
    m_fire    = m_valid && m_ready;
    lat_done  = (lat == LAT_W'(ADD_LAT));
    state_nxt = state;
    case (state)
      ST_IDLE: if (s_fire) state_nxt = s_last ? ST_DONE : ST_ACC;
      ST_ACC:  if (s_fire) state_nxt = ST_WAIT;
      ST_WAIT: if (lat_done) state_nxt = last_q ? ST_DONE : ST_ACC;
      ST_DONE: if (m_fire) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pll or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      started <= 1'b0;
      acc     <= FP27_ZERO;
      add_a   <= FP27_ZERO;
      add_b   <= FP27_ZERO;
      cnt     <= '0;
      lat     <= '0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      case (state)
        ST_IDLE: begin
          // First element seeds the sum directly, so a lone element is bit-exact.
          if (s_fire) begin
            acc <= s_data;
            cnt <= CNT_W'(1);
          end
        end
        ST_ACC: begin
          if (s_fire) begin
            add_a  <= acc;
            add_b  <= s_data;
            last_q <= s_last;
            lat    <= '0;
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          lat <= lat + LAT_W'(1);
          if (lat_done) acc <= add_sum;
        end
        default: ;
      endcase
    end
  end

  assign m_data    = acc;
  assign m_count   = cnt;
  assign state_dbg = state;

endmodule

// File: tb/tb_fp_sum_sequencer.sv
// Directed bench for fp_sum_sequencer with a behavioural two-stage adder; a
// scoreboard queue holds expected {count, sum} and a monitor checks each output beat.
module tb_fp_sum_sequencer;
  import fp27_pkg::*;

  localparam int ADD_LAT = 2;
  localparam int CNT_W   = 16;
  localparam int CNT2_W  = 2;

  localparam logic [26:0] F1_0 = 27'h1FC0000;
  localparam logic [26:0] F1_5 = 27'h1FE0000;
  localparam logic [26:0] F2_0 = 27'h2000000;
  localparam logic [26:0] F3_0 = 27'h2020000;
  localparam logic [26:0] F4_0 = 27'h2040000;
  localparam logic [26:0] F5_0 = 27'h2050000;

  logic              clk_pll;
  logic              rst_n;
  logic              s_valid, s_ready, s_last;
  logic [26:0]       s_data, add_a, add_b, add_sum, m_data;
  logic              m_valid, m_ready;
  logic [CNT_W-1:0]  m_count;
  logic [1:0]        state_dbg;

  logic              s2_valid, s2_ready, s2_last;
  logic [26:0]       s2_data, add2_a, add2_b, add2_sum, m2_data;
  logic              m2_valid, m2_ready;
  logic [CNT2_W-1:0] m2_count;
  logic [1:0]        state2_dbg;

  logic [26:0] p1_q, p2_q, p1b_q, p2b_q;

  logic [CNT_W+26:0]  exp_q[$];
  logic [CNT2_W+26:0] exp2_q[$];
  logic [CNT_W+26:0]  exp_item;
  logic [CNT2_W+26:0] exp2_item;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0]  pat;
  int          nx;
  logic        xf;
  logic [26:0] elems[3];
  int          tmo;

  fp_sum_sequencer #(.ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) u_dut (
    .clk_pll(clk_pll), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
    .state_dbg(state_dbg)
  );

  fp_sum_sequencer #(.ADD_LAT(ADD_LAT), .CNT_W(CNT2_W)) u_dut_sat (
    .clk_pll(clk_pll), .rst_n(rst_n),
    .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data), .s_last(s2_last),
    .add_a(add2_a), .add_b(add2_b), .add_sum(add2_sum),
    .m_valid(m2_valid), .m_ready(m2_ready), .m_data(m2_data), .m_count(m2_count),
    .state_dbg(state2_dbg)
  );

  // ---------------- clock ----------------
  initial clk_pll = 1'b0;
  always #5 clk_pll = ~clk_pll;

  // Positive normal operands only; truncating add.
  function automatic logic [26:0] fadd(input logic [26:0] a, input logic [26:0] b);
    logic [7:0]  ea, eb, e;
    logic [19:0] ma, mb, s;
    int          sh;
    if (a[25:18] == 8'd0) return b;
    if (b[25:18] == 8'd0) return a;
    if (a[25:18] >= b[25:18]) begin
      ea = a[25:18]; eb = b[25:18]; ma = {2'b01, a[17:0]}; mb = {2'b01, b[17:0]};
    end else begin
      ea = b[25:18]; eb = a[25:18]; ma = {2'b01, b[17:0]}; mb = {2'b01, a[17:0]};
    end
    sh = int'(ea) - int'(eb);
    mb = (sh > 19) ? 20'd0 : (mb >> sh);
    s  = ma + mb;
    e  = ea;
    if (s[19]) begin
      s = s >> 1;
      e = e + 8'd1;
    end
    return {1'b0, e, s[17:0]};
  endfunction

  always @(posedge clk_pll) begin
    p1_q  <= fadd(add_a, add_b);
    p2_q  <= p1_q;
    p1b_q <= fadd(add2_a, add2_b);
    p2b_q <= p1b_q;
  end
  assign add_sum  = p2_q;
  assign add2_sum = p2b_q;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk_pll) begin
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(m_data), 64'h0);
      end else begin
        exp_item = exp_q.pop_front();
        check("m_data", 64'(m_data), 64'(exp_item[26:0]));
        check("m_count", 64'(m_count), 64'(exp_item[CNT_W+26:27]));
      end
    end
    if (m2_valid && m2_ready) begin
      if (exp2_q.size() == 0) begin
        check("unexpected_output_sat", 64'(m2_data), 64'h0);
      end else begin
        exp2_item = exp2_q.pop_front();
        check("m_data_sat", 64'(m2_data), 64'(exp2_item[26:0]));
        check("m_count_sat", 64'(m2_count), 64'(exp2_item[CNT2_W+26:27]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [26:0] d, input logic last);
    int t;
    t = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge clk_pll);
    while (!s_ready && t < 100) begin
      @(negedge clk_pll);
      t++;
    end
    check("send_accepted", 64'(s_ready), 64'h1);
    @(posedge clk_pll); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send2(input logic [26:0] d, input logic last);
    int t;
    t = 0;
    s2_valid = 1'b1; s2_data = d; s2_last = last;
    @(negedge clk_pll);
    while (!s2_ready && t < 100) begin
      @(negedge clk_pll);
      t++;
    end
    check("send_accepted_sat", 64'(s2_ready), 64'h1);
    @(posedge clk_pll); #1;
    s2_valid = 1'b0; s2_last = 1'b0;
  endtask

  task automatic wait_mvalid();
    int t;
    t = 0;
    while (!m_valid && t < 50) begin
      @(posedge clk_pll); #1;
      t++;
    end
    check("m_valid_arrives", 64'(m_valid), 64'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    s2_valid = 1'b0; s2_data = '0; s2_last = 1'b0; m2_ready = 1'b1;
    repeat (3) @(posedge clk_pll);
    #1;
    check("rst_s_ready", 64'(s_ready), 64'h0);
    check("rst_m_valid", 64'(m_valid), 64'h0);
    check("rst_add_a", 64'(add_a), 64'h0);
    check("rst_add_b", 64'(add_b), 64'h0);
    check("rst_m_data", 64'(m_data), 64'h0);
    check("rst_m_count", 64'(m_count), 64'h0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(posedge clk_pll); #1;
    check("s_ready_after_release", 64'(s_ready), 64'h1);

    // 1.0 + 2.0 = 3.0, sum captured at E0+3
    exp_q.push_back({16'd2, F3_0});
    send(F1_0, 1'b0);
    send(F2_0, 1'b1);
    check("add_a_e0", 64'(add_a), 64'(F1_0));
    check("add_b_e0", 64'(add_b), 64'(F2_0));
    repeat (2) @(posedge clk_pll);
    #1;
    check("m_valid_e0p2", 64'(m_valid), 64'h0);
    @(posedge clk_pll); #1;
    check("m_valid_e0p3", 64'(m_valid), 64'h1);
    repeat (2) @(posedge clk_pll);
    #1;

    // single element: bit-exact, adder operands untouched
    exp_q.push_back({16'd1, F1_5});
    send(F1_5, 1'b1);
    check("single_m_valid", 64'(m_valid), 64'h1);
    check("single_add_a_held", 64'(add_a), 64'(F1_0));
    check("single_add_b_held", 64'(add_b), 64'(F2_0));
    repeat (2) @(posedge clk_pll);
    #1;

    // four x 1.0 with a stalled consumer
    m_ready = 1'b0;
    exp_q.push_back({16'd4, F4_0});
    for (int i = 0; i < 4; i++) send(F1_0, i == 3);
    wait_mvalid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_pll);
      check("stall_m_valid", 64'(m_valid), 64'h1);
      check("stall_m_data", 64'(m_data), 64'(F4_0));
      check("stall_m_count", 64'(m_count), 64'd4);
      check("stall_s_ready", 64'(s_ready), 64'h0);
    end
    @(posedge clk_pll); #1;
    m_ready = 1'b1;
    check("s_ready_in_m_xfer", 64'(s_ready), 64'h0);
    @(posedge clk_pll); #1;
    check("s_ready_after_m_xfer", 64'(s_ready), 64'h1);
    check("m_valid_after_m_xfer", 64'(m_valid), 64'h0);

    // s_valid held high across a 3-element packet: 1.0 + 2.0 + 1.0
    elems[0] = F1_0; elems[1] = F2_0; elems[2] = F1_0;
    exp_q.push_back({16'd3, F4_0});
    pat = '0; nx = 0;
    s_valid = 1'b1; s_data = elems[0]; s_last = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_pll);
      pat[8-i] = s_ready;
      xf = s_valid && s_ready;
      @(posedge clk_pll); #1;
      if (xf) begin
        nx++;
        if (nx == 3) begin
          s_valid = 1'b0; s_last = 1'b0;
        end else begin
          s_data = elems[nx]; s_last = (nx == 2);
        end
      end
    end
    check("s_ready_pattern", 64'(pat), 64'(9'b110001000));
    check("elements_consumed", 64'(nx), 64'd3);
    repeat (3) @(posedge clk_pll);
    #1;

    // reset pulse in WAIT discards the partial packet
    send(F1_0, 1'b0);
    send(F2_0, 1'b1);
    @(posedge clk_pll); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_add_a", 64'(add_a), 64'h0);
    check("midrst_add_b", 64'(add_b), 64'h0);
    check("midrst_m_valid", 64'(m_valid), 64'h0);
    check("midrst_s_ready", 64'(s_ready), 64'h0);
    check("midrst_m_data", 64'(m_data), 64'h0);
    check("midrst_m_count", 64'(m_count), 64'h0);
    @(posedge clk_pll); #1;
    rst_n = 1'b1;
    @(posedge clk_pll); #1;
    exp_q.push_back({16'd1, F2_0});
    send(F2_0, 1'b1);
    repeat (3) @(posedge clk_pll);
    #1;

    // 2-bit counter saturates at 3 while the sum reaches 5.0
    exp2_q.push_back({2'd3, F5_0});
    for (int i = 0; i < 5; i++) send2(F1_0, i == 4);

    tmo = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && tmo < 50) begin
      @(posedge clk_pll); #1;
      tmo++;
    end
    check("scoreboard_drained", 64'(exp_q.size() + exp2_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
